// File: rtl/anc_pkg.sv
// Shared scheduler types and default sizing for the ANC core.
// anc_top imports this package so that both sides agree on the tap count.
package anc_pkg;
  localparam int DEF_NTAPS = 16;
  localparam int DEF_DLY_W = 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FIR,
    S_EMIT,
    S_WAIT,
    S_UPDATE,
    S_WLOAD
  } sched_state_t;
endpackage

// File: rtl/anc_phase_cnt.sv
// Loadable down-counter that saturates at zero; done flags the zero count.
module anc_phase_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         done
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign done = (cnt_q == '0);
endmodule

// File: rtl/anc_frame_sched.sv
// Per-sample phase scheduler: FIR -> EMIT -> optional WAIT -> LMS update or weight load.
// All phase enables are decoded from the state register and the two phase counters.
module anc_frame_sched
  import anc_pkg::*;
#(
  parameter int NTAPS = DEF_NTAPS,
  parameter int TAP_W = $clog2(NTAPS),
  parameter int DLY_W = DEF_DLY_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init_done,
  input  logic             bypass_mode_sel,
  input  logic [DLY_W-1:0] prog_delay_sel,
  input  logic             in_valid,
  output logic             controller_ready,
  output logic             cap_en,
  input  logic             bypass_valid,
  output logic [TAP_W-1:0] tap_idx,
  output logic             mac_clr,
  output logic             fir_act,
  output logic             out_valid,
  output logic             lms_en,
  output logic             wload_en,
  output logic             busy
);
  localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(NTAPS - 1);

  sched_state_t     state_q, state_d;
  logic             mode_q, mode_d;
  logic             hs;
  logic             tap_load, tap_dec, tap_done;
  logic             dly_load, dly_dec, dly_done;
  logic [TAP_W-1:0] tap_cnt;
  logic [DLY_W-1:0] dly_cnt;

  // Tap counter runs NTAPS-1 down to 0; tap_idx is its complement.
  anc_phase_cnt #(.W(TAP_W)) u_tap_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (tap_load),
    .load_val (TAP_LAST),
    .dec      (tap_dec),
    .cnt      (tap_cnt),
    .done     (tap_done)
  );

  // Delay counter doubles as the frame-latched delay value.
  anc_phase_cnt #(.W(DLY_W)) u_dly_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (dly_load),
    .load_val (prog_delay_sel),
    .dec      (dly_dec),
    .cnt      (dly_cnt),
    .done     (dly_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    tap_load = 1'b0;
    tap_dec  = 1'b0;
    dly_load = 1'b0;
    dly_dec  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (hs) begin
          state_d  = S_FIR;
          mode_d   = bypass_mode_sel;
          tap_load = 1'b1;
          dly_load = 1'b1;
        end
      end
      S_FIR: begin
        tap_dec = 1'b1;
        if (tap_done) state_d = S_EMIT;
      end
      S_EMIT: begin
        if (!dly_done) begin
          state_d = S_WAIT;
        end else begin
          tap_load = 1'b1;
          state_d  = mode_q ? S_WLOAD : S_UPDATE;
        end
      end
      S_WAIT: begin
        dly_dec = 1'b1;
        if (dly_cnt == DLY_W'(1)) begin
          tap_load = 1'b1;
          state_d  = mode_q ? S_WLOAD : S_UPDATE;
        end
      end
      S_UPDATE: begin
        tap_dec = 1'b1;
        if (tap_done) state_d = S_IDLE;
      end
      S_WLOAD: begin
        if (bypass_valid) begin
          tap_dec = 1'b1;
          if (tap_done) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    controller_ready = (state_q == S_IDLE) && init_done;
    hs               = in_valid && controller_ready;
    cap_en           = hs;
    fir_act          = (state_q == S_FIR);
    mac_clr          = (state_q == S_FIR) && (tap_cnt == TAP_LAST);
    out_valid        = (state_q == S_EMIT);
    lms_en           = (state_q == S_UPDATE);
    wload_en         = (state_q == S_WLOAD) && bypass_valid;
    busy             = (state_q != S_IDLE);
    tap_idx          = '0;
    if ((state_q == S_FIR) || (state_q == S_UPDATE) || (state_q == S_WLOAD)) begin
      tap_idx = TAP_LAST - tap_cnt;
    end
  end
endmodule

// File: tb/tb_anc_frame_sched.sv
// Directed bench for anc_frame_sched: each frame is checked cycle by cycle against its timeline.
module tb_anc_frame_sched;
  localparam int NT = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       init_done;
  logic       bypass_mode_sel;
  logic [4:0] prog_delay_sel;
  logic       in_valid;
  logic       controller_ready;
  logic       cap_en;
  logic       bypass_valid;
  logic [3:0] tap_idx;
  logic       mac_clr;
  logic       fir_act;
  logic       out_valid;
  logic       lms_en;
  logic       wload_en;
  logic       busy;

  int n_err    = 0;
  int n_checks = 0;

  always #5 clk = ~clk;

  anc_frame_sched dut (
    .clk              (clk),
    .rst              (rst),
    .init_done        (init_done),
    .bypass_mode_sel  (bypass_mode_sel),
    .prog_delay_sel   (prog_delay_sel),
    .in_valid         (in_valid),
    .controller_ready (controller_ready),
    .cap_en           (cap_en),
    .bypass_valid     (bypass_valid),
    .tap_idx          (tap_idx),
    .mac_clr          (mac_clr),
    .fir_act          (fir_act),
    .out_valid        (out_valid),
    .lms_en           (lms_en),
    .wload_en         (wload_en),
    .busy             (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic expect_outs(input string tag, input bit f, input int tap, input bit clr,
                             input bit ov, input bit lms, input bit wl, input bit bsy,
                             input bit rdy, input bit cap);
    chk({tag, ".fir_act"}, 32'(fir_act), 32'(f));
    chk({tag, ".tap_idx"}, 32'(tap_idx), 32'(tap));
    chk({tag, ".mac_clr"}, 32'(mac_clr), 32'(clr));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
    chk({tag, ".lms_en"}, 32'(lms_en), 32'(lms));
    chk({tag, ".wload_en"}, 32'(wload_en), 32'(wl));
    chk({tag, ".busy"}, 32'(busy), 32'(bsy));
    chk({tag, ".ready"}, 32'(controller_ready), 32'(rdy));
    chk({tag, ".cap_en"}, 32'(cap_en), 32'(cap));
  endtask

  // Caller is at the input-setting point of an IDLE cycle; this handshakes and
  // follows the frame to the IDLE cycle after it.
  task automatic run_frame(input string tag, input int d, input bit mode, input int bvp,
                           input bit hold_v, input bit mid_change, input bit drop_init);
    int  c;
    int  u0;
    int  pulses;
    bit  in_wl, bv_now, idle_exp;
    bit  f, clr, ov, lms;
    int  tap;
    u0     = NT + 2 + d;
    pulses = 0;
    in_valid        = 1'b1;
    bypass_mode_sel = mode;
    prog_delay_sel  = 5'(d);
    bypass_valid    = 1'b0;
    #1;
    chk({tag, ".hs_ready"}, 32'(controller_ready), 32'd1);
    chk({tag, ".hs_cap"}, 32'(cap_en), 32'd1);
    c = 0;
    forever begin
      c++;
      tick();
      idle_exp = mode ? (pulses == NT) : (c >= u0 + NT);
      in_wl    = mode && (c >= u0) && (pulses < NT);
      bv_now   = (c == 5) || (in_wl && (((c - u0) % bvp) == bvp - 1));
      in_valid     = hold_v;
      bypass_valid = bv_now;
      if (mid_change && c == 5) begin
        bypass_mode_sel = ~mode;
        prog_delay_sel  = 5'd7;
      end
      if (drop_init && c == 10) init_done = 1'b0;
      #1;
      if (idle_exp) begin
        chk({tag, ".end_busy"}, 32'(busy), 32'd0);
        chk({tag, ".end_tap"}, 32'(tap_idx), 32'd0);
        chk({tag, ".end_ov"}, 32'(out_valid), 32'd0);
        $display("frame %s: d=%0d mode=%0d back in IDLE at cycle %0d", tag, d, mode, c);
        break;
      end
      if (c > 200) begin
        chk({tag, ".timeout_busy"}, 32'(busy), 32'd0);
        break;
      end
      f   = (c >= 1) && (c <= NT);
      clr = (c == 1);
      ov  = (c == NT + 1);
      lms = !mode && (c >= u0) && (c < u0 + NT);
      tap = f ? c - 1 : lms ? c - u0 : in_wl ? pulses : 0;
      expect_outs($sformatf("%s.c%0d", tag, c), f, tap, clr, ov, lms, in_wl && bv_now,
                  1'b1, 1'b0, 1'b0);
      if (in_wl && bv_now) pulses++;
    end
    bypass_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; init_done = 1'b0; bypass_mode_sel = 1'b0; prog_delay_sel = '0;
    in_valid = 1'b0; bypass_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    expect_outs("reset", 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // init_done low: no handshake despite in_valid
    for (int i = 0; i < 4; i++) begin
      tick();
      in_valid = 1'b1;
      #1;
      expect_outs($sformatf("noinit.%0d", i), 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    tick();
    in_valid  = 1'b0;
    init_done = 1'b1;
    #1;
    chk("ready_follows_init", 32'(controller_ready), 32'd1);

    run_frame("d3_lms", 3, 1'b0, 1, 1'b0, 1'b0, 1'b0);
    run_frame("b2b_a", 0, 1'b0, 1, 1'b1, 1'b0, 1'b0);
    run_frame("b2b_b", 0, 1'b0, 1, 1'b1, 1'b0, 1'b0);
    in_valid = 1'b0;
    run_frame("wload_p3", 0, 1'b1, 3, 1'b0, 1'b0, 1'b0);
    run_frame("midchg_d2", 2, 1'b0, 1, 1'b0, 1'b1, 1'b0);
    run_frame("after_chg_d7", 7, 1'b1, 1, 1'b0, 1'b0, 1'b0);

    run_frame("drop_init", 0, 1'b0, 1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      #1;
      chk($sformatf("held_idle.ready%0d", i), 32'(controller_ready), 32'd0);
      chk($sformatf("held_idle.cap%0d", i), 32'(cap_en), 32'd0);
      tick();
      chk($sformatf("held_idle.busy%0d", i), 32'(busy), 32'd0);
    end
    in_valid  = 1'b0;
    init_done = 1'b1;

    // reset during FIR cycle 8
    in_valid = 1'b1; bypass_mode_sel = 1'b0; prog_delay_sel = 5'd0;
    #1;
    chk("rstmid.cap", 32'(cap_en), 32'd1);
    for (int c = 1; c <= 8; c++) begin
      tick();
      in_valid = 1'b0;
      #1;
      chk($sformatf("rstmid.fir%0d", c), 32'(fir_act), 32'd1);
      chk($sformatf("rstmid.tap%0d", c), 32'(tap_idx), 32'(c - 1));
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    expect_outs("rstmid.after", 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk($sformatf("rstmid.no_ov%0d", i), 32'(out_valid), 32'd0);
    end
    run_frame("post_rst_d1", 1, 1'b0, 1, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/anc_frame_sched.md
# anc_frame_sched

Per-sample phase scheduler for the ANC datapath. It accepts one merged sample-valid from the four I2S receivers and drives `controller_ready`. For each accepted frame it sequences the core through FIR accumulation, output emission, a programmable alignment delay, and then either an LMS weight update or an FPGA weight-injection load. It owns every per-tap index and phase enable seen by `anc_top`; the datapath itself holds no sequencing state.

## Interface
- `NTAPS`, 16: filter length, ≥2.
- `TAP_W`, `$clog2(NTAPS)`: tap index width.
- `DLY_W`, 5: width of `prog_delay_sel`.

- `clk` in 1: system clock.
- `rst` in 1: reset, synchronous, active-high.
- `init_done` in 1: config shift-in complete.
- `bypass_mode_sel` in 1: 1 = weights loaded from FPGA instead of LMS.
- `prog_delay_sel` in `DLY_W`: idle cycles between EMIT and the update phase.
- `in_valid` in 1: merged e/x/a/u sample valid.
- `controller_ready` out 1: scheduler can accept a frame.
- `cap_en` out 1: latch e/x/a/u into datapath sample registers.
- `bypass_valid` in 1: one injected weight present on `weight_inject`.
- `tap_idx` out `TAP_W`: tap addressed by the current phase.
- `mac_clr` out 1: clear FIR accumulator before tap 0.
- `fir_act` out 1: FIR MAC enable.
- `out_valid` out 1: single-cycle pulse, `out_sample` valid.
- `lms_en` out 1: LMS update enable for `tap_idx`.
- `wload_en` out 1: write `weight_inject` into weight `tap_idx`.
- `busy` out 1: state ≠ IDLE.

## Operation
- States: IDLE, FIR, EMIT, WAIT, UPDATE, WLOAD.
- IDLE:
  - `controller_ready` = `init_done` (combinational).
  - Handshake = `in_valid & controller_ready`.
  - On handshake, `cap_en`=1 in the same cycle. `bypass_mode_sel` → `mode_q` and `prog_delay_sel` → `dly_q` are registered, `tap_idx`←0, next state FIR.
- FIR: `fir_act`=1 for NTAPS cycles, with `tap_idx` running 0..NTAPS-1. `mac_clr`=1 only in the first FIR cycle. After `tap_idx`=NTAPS-1, go to EMIT.
- EMIT: `out_valid`=1 for exactly one cycle.
  - Next state is WAIT if `dly_q`≠0.
  - Otherwise UPDATE if `mode_q`=0, or WLOAD if `mode_q`=1.
- WAIT: down-count `dly_q` to 1, then go to UPDATE/WLOAD. The total number of WAIT cycles equals the latched `dly_q`.
- UPDATE: `lms_en`=1 for NTAPS cycles with `tap_idx` 0..NTAPS-1, then IDLE.
- WLOAD:
  - `tap_idx` starts at 0 and advances only on cycles where `bypass_valid`=1; `wload_en`=`bypass_valid`.
  - After the NTAPS-th pulse, go to IDLE.
  - There is no timeout: the FPGA must supply exactly NTAPS pulses.
- `bypass_valid` outside WLOAD is ignored, with no side effects.
- Mode and delay are frame-latched. Changing `bypass_mode_sel` or `prog_delay_sel` mid-frame has no effect until the next handshake.
- If `init_done` drops mid-frame, the frame completes and the scheduler then holds in IDLE with `controller_ready`=0.
- All phase enables are mutually exclusive; at most one of `fir_act`, `out_valid`, `lms_en`, `wload_en` is high in any cycle.
- `tap_idx` is 0 in IDLE, EMIT and WAIT. It wraps to 0 on each phase entry and never exceeds NTAPS-1.

## Timing
- Reset: state IDLE, `tap_idx`=0, all outputs 0. `controller_ready` follows `init_done` combinationally from the first post-reset cycle. A reset mid-frame aborts at the next edge with no `out_valid` emitted.
- With the handshake at cycle 0:
  - FIR occupies cycles 1..NTAPS.
  - `out_valid` is at cycle NTAPS+1.
  - WAIT occupies cycles NTAPS+2..NTAPS+1+D.
  - UPDATE occupies the next NTAPS cycles.
  - `controller_ready` returns at cycle 2·NTAPS+2+D.
- In WLOAD, return to IDLE is the cycle after the NTAPS-th `bypass_valid`.
- Back-to-back: `in_valid` held high gives a handshake on the first IDLE cycle. There is no dead cycle beyond IDLE itself.
- Outputs other than `controller_ready` and `cap_en` are registered, decoded from state and counter only.

## Structure
- `anc_pkg`: state enum `sched_state_t`, default `NTAPS`, `DLY_W`. This package is shared with `anc_top` for tap-count agreement.
- Sub-module `anc_phase_cnt`: loadable down-counter with `done` flag. It is instantiated twice: once for tap count, once for WAIT delay.
- One FSM `always` block plus registered output decode. No datapath arithmetic.

## Test plan
- NTAPS=16, D=3, mode 0, `in_valid` pulse at cycle 0:
  - `fir_act` high over cycles 1–16 with `tap_idx` 0..15.
  - `mac_clr` only at cycle 1.
  - `out_valid` at cycle 17.
  - `lms_en` over cycles 21–36.
  - `controller_ready` back at cycle 37.
- D=0, `in_valid` held high continuously: UPDATE over cycles 18–33, second handshake at cycle 34, `cap_en` pulses exactly at cycles 0 and 34.
- Mode 1, `bypass_valid` pulsed every 3rd cycle after EMIT: 16 `wload_en` pulses with `tap_idx` 0..15. IDLE the cycle after the 16th pulse. Stray `bypass_valid` during FIR gives no `wload_en`.
- `init_done`=0 with `in_valid`=1: `controller_ready`=0 and the FSM stays in IDLE. Deassert `init_done` at cycle 10 of a frame: the frame completes, then `controller_ready` stays 0.
- Toggle `bypass_mode_sel` and set `prog_delay_sel`=7 at cycle 5 of a mode-0, D=2 frame: 2 WAIT cycles then UPDATE. The next frame uses WLOAD with D=7.
- Assert `rst` at cycle 8 of FIR: the next cycle is IDLE, `tap_idx`=0, and no `out_valid` occurs. A new handshake sequences normally.
